loom_dpi_bridge: RTL and testbench
==================================

# loom_dpi_bridge

Per-function DPI call mailbox that sits directly upstream of the emulation controller and drives one bit of its DPI stall vector. When the transformed DUT raises a call request, the bridge holds the stall high, latches the call arguments, and exposes them to the host over AXI-Lite. It then waits for the host to write a result and a DONE command, returns the result to the DUT, and releases the stall. One instance exists per DPI function; the controller ORs all stall outputs together.

## Interface
Parameters:
- FUNC_ID, 0: function index; read back in STATUS[15:8].
- N_ARGS, 4: number of 32-bit arguments. Legal range is 1..8.

Ports:
- clk_i  in  1  system clock. One clock only.
- rst_i  in  1  synchronous, active-high reset.
- axil_ar*/r*/aw*/w*/b*  AXI-Lite slave, 8-bit address, 32-bit data. Same signal set as the controller's register port.
- dpi_valid_i  in  1  DUT call request, held by the DUT until it retires.
- dpi_args_i  in  32*N_ARGS  call arguments. Arg i occupies bits [32i+31:32i].
- dpi_ret_o  out  32  result returned to the DUT.
- dpi_ret_valid_o  out  1  result valid. High only in StRetire.
- emu_clk_en_i  in  1  DUT clock enable from the emulation controller.
- stall_o  out  1  to the controller's dpi_stall_i bit.
- irq_o  out  1  call-pending interrupt.

## Operation
State machine:
- StIdle → StPending when dpi_valid_i=1.
  - On the same edge, latch dpi_args_i into arg registers.
  - The latch happens regardless of emu_clk_en_i.
- StPending → StRetire on a performed write to CONTROL with bit0=1 (DONE).
  - On the same edge, dpi_ret_o is loaded from the RESULT register.
  - On the same edge, call_count is incremented by 1, wrapping at 2^32.
- StRetire → StIdle on the first edge with emu_clk_en_i=1, i.e. after the DUT has consumed the result.
  - This prevents the same held request from being recaptured.

Output equations:
- stall_o = (StIdle & dpi_valid_i) | StPending.
  - This path is combinational, so the DUT never ticks past the call.
  - stall_o=0 in StRetire.
- dpi_ret_valid_o = StRetire.
- irq_o = StPending & irq_en.

Register map (word-aligned; address bits [1:0] are ignored):
- 0x00 STATUS, R: {16'd0, FUNC_ID[7:0], 5'd0, N_ARGS==0?0:1'b0... no: bit2=0, bit1=StRetire, bit0=StPending}. Bits [7:2] read as 0.
- 0x04 CONTROL, W:
  - bit0 = DONE.
  - DONE is ignored outside StPending, but the write still receives OKAY.
  - CONTROL reads as 0.
- 0x08 RESULT, RW: 32-bit. Writable in any state.
- 0x0C CALL_COUNT, R: completed calls.
- 0x10 IRQ_ENABLE, RW: bit0 = irq_en. Upper bits read as 0.
- 0x20+4i ARG[i], R, for i < N_ARGS.
  - ARG registers hold their value until the next capture.
- Any other address reads 0xDEADBEEF. Writes to it are dropped.
- bresp and rresp are always OKAY (2'b00).

## Timing
Reset values (rst_i high at an edge):
- State StIdle.
- All arg registers, RESULT, dpi_ret_o, call_count and irq_en = 0.
- arready/awready/wready/rvalid/bvalid = 0; rdata = 0.
- stall_o and irq_o follow their equations (0 unless dpi_valid_i is high).
- A reset during StPending or StRetire aborts the call. The DUT sees stall_o follow dpi_valid_i in the cycle after the reset edge.

Ready signals:
- arready, awready and wready go to 1 on the first edge after reset deasserts and stay at 1.

Read timing:
- The address is accepted at edge N.
- rdata/rvalid are registered at edge N+1.
- rvalid holds until rready is sampled high.
- While a response is outstanding, further addresses are captured but not answered until rvalid drops. At most one read is in flight.

Write timing:
- AW and W are captured independently, in either order.
- The write is performed on the edge after both have been captured and bvalid=0; bvalid rises on that same edge.
- Register side effects are visible from that edge onward.
- bvalid holds until bready is sampled high.

Simultaneous events:
- A RESULT write and a DONE write cannot be performed on the same edge. RESULT must be written first.
- A DONE write in the same cycle as a fresh dpi_valid_i while in StIdle is ignored. The call is still captured.
- A back-to-back call (dpi_valid_i still high after the StRetire → StIdle edge) is captured on the next edge. stall_o rises combinationally.

## Test plan
- Reset with dpi_valid_i=0 → stall_o=0, STATUS=FUNC_ID<<8, CALL_COUNT=0, ARG0=0.
- Raise dpi_valid_i with args {1,2,3,4} → stall_o=1 in the same cycle. ARG0..3 read 1..4. STATUS bit0=1. With IRQ_ENABLE=1, irq_o=1.
- Write RESULT=0xCAFE0001, then CONTROL=1 → dpi_ret_o=0xCAFE0001, dpi_ret_valid_o=1, stall_o=0. With emu_clk_en_i held 0 for 5 cycles the state stays StRetire; on the first high it goes to StIdle and CALL_COUNT=1.
- CONTROL=1 written in StIdle → state unchanged, bresp=OKAY, CALL_COUNT unchanged.
- Two back-to-back calls with dpi_valid_i held high → second capture on the edge after retire. CALL_COUNT=2 after both DONEs.
- rst_i pulsed in StPending → StIdle, stall_o tracks dpi_valid_i, arg registers are 0, and an unmapped read at 0x40 returns 0xDEADBEEF.

Source files
------------

// File: rtl/loom_dpi_bridge.sv
// Per-function DPI call mailbox: stalls the DUT on a call request, exposes the
// latched arguments to the host over AXI-Lite and returns the host's result.
module loom_dpi_bridge #(
   parameter int FUNC_ID = 0,
   parameter int N_ARGS  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [7:0]            axil_araddr_i,
   input  logic                  axil_arvalid_i,
   output logic                  axil_arready_o,
   output logic [31:0]           axil_rdata_o,
   output logic [1:0]            axil_rresp_o,
   output logic                  axil_rvalid_o,
   input  logic                  axil_rready_i,
   input  logic [7:0]            axil_awaddr_i,
   input  logic                  axil_awvalid_i,
   output logic                  axil_awready_o,
   input  logic [31:0]           axil_wdata_i,
   input  logic                  axil_wvalid_i,
   output logic                  axil_wready_o,
   output logic [1:0]            axil_bresp_o,
   output logic                  axil_bvalid_o,
   input  logic                  axil_bready_i,
   input  logic                  dpi_valid_i,
   input  logic [32*N_ARGS-1:0]  dpi_args_i,
   output logic [31:0]           dpi_ret_o,
   output logic                  dpi_ret_valid_o,
   input  logic                  emu_clk_en_i,
   output logic                  stall_o,
   output logic                  irq_o
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StPending = 2'd1,
      StRetire  = 2'd2
   } state_t;

   localparam logic [5:0] A_STATUS  = 6'h00;
   localparam logic [5:0] A_CONTROL = 6'h01;
   localparam logic [5:0] A_RESULT  = 6'h02;
   localparam logic [5:0] A_COUNT   = 6'h03;
   localparam logic [5:0] A_IRQEN   = 6'h04;

   state_t        state;
   state_t        state_next;
   logic [31:0]   args [8];
   logic [255:0]  args_pad;
   logic [31:0]   result;
   logic [31:0]   call_count;
   logic          irq_en;
   logic [5:0]    ar_addr;
   logic          ar_pend;
   logic [5:0]    aw_addr;
   logic          aw_pend;
   logic [31:0]   w_data;
   logic          w_pend;
   logic          capture;
   logic          wr_fire;
   logic          done_fire;
   logic          rd_fire;
   logic          arg_hit;
   logic [31:0]   rd_mux;
   logic          unused_addr_bits;

   // Byte-offset bits never select a register
   assign unused_addr_bits = ^{axil_araddr_i[1:0], axil_awaddr_i[1:0]};

   assign args_pad  = 256'(dpi_args_i);
   assign capture   = (state == StIdle) & dpi_valid_i;
   assign wr_fire   = aw_pend & w_pend & ~axil_bvalid_o;
   assign done_fire = wr_fire & (aw_addr == A_CONTROL) & w_data[0] & (state == StPending);
   assign rd_fire   = ar_pend & ~axil_rvalid_o;
   assign arg_hit   = (ar_addr[5:3] == 3'b001) && (int'(ar_addr[2:0]) < N_ARGS);

   assign axil_rresp_o = 2'b00;
   assign axil_bresp_o = 2'b00;

   // Call state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= StIdle;
      end else begin
         state <= state_next;
      end
   end

   // Call state transitions
   always_comb begin
      state_next = state;
      case (state)
         StIdle: begin
            if (dpi_valid_i) state_next = StPending;
            else             state_next = StIdle;
         end
         StPending: begin
            if (done_fire) state_next = StRetire;
            else           state_next = StPending;
         end
         StRetire: begin
            // Leave only once the DUT has ticked and consumed the result
            if (emu_clk_en_i) state_next = StIdle;
            else              state_next = StRetire;
         end
         default: state_next = StIdle;
      endcase
   end

   // Stall is combinational so the DUT cannot tick past a fresh call
   always_comb begin
      stall_o         = 1'b0;
      dpi_ret_valid_o = 1'b0;
      irq_o           = 1'b0;
      case (state)
         StIdle:    stall_o = dpi_valid_i;
         StPending: begin
            stall_o = 1'b1;
            irq_o   = irq_en;
         end
         StRetire:  dpi_ret_valid_o = 1'b1;
         default:   stall_o = 1'b0;
      endcase
   end

   // Argument capture on call entry
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 8; i++) args[i] <= 32'd0;
      end else if (capture) begin
         for (int i = 0; i < 8; i++) begin
            if (i < N_ARGS) args[i] <= args_pad[32*i +: 32];
            else            args[i] <= 32'd0;
         end
      end
   end

   // Mailbox registers and call retirement bookkeeping
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result     <= 32'd0;
         irq_en     <= 1'b0;
         dpi_ret_o  <= 32'd0;
         call_count <= 32'd0;
      end else begin
         if (wr_fire && (aw_addr == A_RESULT)) result <= w_data;
         if (wr_fire && (aw_addr == A_IRQEN))  irq_en <= w_data[0];
         if (done_fire) begin
            dpi_ret_o  <= result;
            call_count <= call_count + 32'd1;
         end
      end
   end

   // Write channel: AW and W captured independently, then performed together
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         axil_awready_o <= 1'b0;
         axil_wready_o  <= 1'b0;
         axil_bvalid_o  <= 1'b0;
         aw_addr        <= 6'd0;
         aw_pend        <= 1'b0;
         w_data         <= 32'd0;
         w_pend         <= 1'b0;
      end else begin
         axil_awready_o <= 1'b1;
         axil_wready_o  <= 1'b1;
         if (axil_awvalid_i && axil_awready_o) begin
            aw_addr <= axil_awaddr_i[7:2];
            aw_pend <= 1'b1;
         end else if (wr_fire) begin
            aw_pend <= 1'b0;
         end
         if (axil_wvalid_i && axil_wready_o) begin
            w_data <= axil_wdata_i;
            w_pend <= 1'b1;
         end else if (wr_fire) begin
            w_pend <= 1'b0;
         end
         if (wr_fire)                            axil_bvalid_o <= 1'b1;
         else if (axil_bvalid_o && axil_bready_i) axil_bvalid_o <= 1'b0;
      end
   end

   // Read data select
   always_comb begin
      rd_mux = 32'hDEAD_BEEF;
      case (ar_addr)
         A_STATUS:  rd_mux = {16'd0, 8'(FUNC_ID), 6'd0, state == StRetire, state == StPending};
         A_CONTROL: rd_mux = 32'd0;
         A_RESULT:  rd_mux = result;
         A_COUNT:   rd_mux = call_count;
         A_IRQEN:   rd_mux = {31'd0, irq_en};
         default: begin
            if (arg_hit) rd_mux = args[ar_addr[2:0]];
            else         rd_mux = 32'hDEAD_BEEF;
         end
      endcase
   end

   // Read channel: one address slot, answered once the previous response drains
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         axil_arready_o <= 1'b0;
         axil_rvalid_o  <= 1'b0;
         axil_rdata_o   <= 32'd0;
         ar_addr        <= 6'd0;
         ar_pend        <= 1'b0;
      end else begin
         axil_arready_o <= 1'b1;
         if (axil_arvalid_i && axil_arready_o) begin
            ar_addr <= axil_araddr_i[7:2];
            ar_pend <= 1'b1;
         end else if (rd_fire) begin
            ar_pend <= 1'b0;
         end
         if (rd_fire) begin
            axil_rvalid_o <= 1'b1;
            axil_rdata_o  <= rd_mux;
         end else if (axil_rvalid_o && axil_rready_i) begin
            axil_rvalid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_loom_dpi_bridge.sv
// Bench for loom_dpi_bridge: register-access vector table, directed call
// sequences and randomized calls checked against a call-level model.
module tb_loom_dpi_bridge;
   localparam int FID = 90;
   localparam int NA  = 4;

   logic              clk = 1'b0;
   logic              rst_i;
   logic [7:0]        axil_araddr_i;
   logic              axil_arvalid_i;
   logic              axil_arready_o;
   logic [31:0]       axil_rdata_o;
   logic [1:0]        axil_rresp_o;
   logic              axil_rvalid_o;
   logic              axil_rready_i;
   logic [7:0]        axil_awaddr_i;
   logic              axil_awvalid_i;
   logic              axil_awready_o;
   logic [31:0]       axil_wdata_i;
   logic              axil_wvalid_i;
   logic              axil_wready_o;
   logic [1:0]        axil_bresp_o;
   logic              axil_bvalid_o;
   logic              axil_bready_i;
   logic              dpi_valid_i;
   logic [32*NA-1:0]  dpi_args_i;
   logic [31:0]       dpi_ret_o;
   logic              dpi_ret_valid_o;
   logic              emu_clk_en_i;
   logic              stall_o;
   logic              irq_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   loom_dpi_bridge #(.FUNC_ID(FID), .N_ARGS(NA)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .axil_araddr_i(axil_araddr_i), .axil_arvalid_i(axil_arvalid_i), .axil_arready_o(axil_arready_o),
      .axil_rdata_o(axil_rdata_o), .axil_rresp_o(axil_rresp_o), .axil_rvalid_o(axil_rvalid_o),
      .axil_rready_i(axil_rready_i),
      .axil_awaddr_i(axil_awaddr_i), .axil_awvalid_i(axil_awvalid_i), .axil_awready_o(axil_awready_o),
      .axil_wdata_i(axil_wdata_i), .axil_wvalid_i(axil_wvalid_i), .axil_wready_o(axil_wready_o),
      .axil_bresp_o(axil_bresp_o), .axil_bvalid_o(axil_bvalid_o), .axil_bready_i(axil_bready_i),
      .dpi_valid_i(dpi_valid_i), .dpi_args_i(dpi_args_i), .dpi_ret_o(dpi_ret_o),
      .dpi_ret_valid_o(dpi_ret_valid_o), .emu_clk_en_i(emu_clk_en_i),
      .stall_o(stall_o), .irq_o(irq_o)
   );

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data);
      bit got = 1'b0;
      axil_awaddr_i  = addr;
      axil_wdata_i   = data;
      axil_awvalid_i = 1'b1;
      axil_wvalid_i  = 1'b1;
      @(posedge clk);
      #1;
      axil_awvalid_i = 1'b0;
      axil_wvalid_i  = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (axil_bvalid_o) got = 1'b1;
      end
      if (!got) chk1("bvalid_timeout", 1'b0, 1'b1);
      else      chk("bresp", {30'd0, axil_bresp_o}, 32'd0);
   endtask

   task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
      bit got = 1'b0;
      data = 32'd0;
      axil_araddr_i  = addr;
      axil_arvalid_i = 1'b1;
      @(posedge clk);
      #1;
      axil_arvalid_i = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (axil_rvalid_o) begin
            got  = 1'b1;
            data = axil_rdata_o;
         end
      end
      if (!got) chk1("rvalid_timeout", 1'b0, 1'b1);
   endtask

   task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(addr, d);
      chk(name, d, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] res;
      logic [31:0] m_args [NA];
      logic [31:0] m_count;
      logic [31:0] status_base;
      logic        ie;
      int          ai;
      int          k;

      status_base = 32'(FID) << 8;
      m_count     = 32'd0;

      vecs[0]  = '{1'b0, 8'h00, status_base};
      vecs[1]  = '{1'b0, 8'h0C, 32'd0};
      vecs[2]  = '{1'b0, 8'h20, 32'd0};
      vecs[3]  = '{1'b0, 8'h40, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 8'h30, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b0, 8'h14, 32'hDEAD_BEEF};
      vecs[6]  = '{1'b1, 8'h08, 32'h1234_5678};
      vecs[7]  = '{1'b0, 8'h08, 32'h1234_5678};
      vecs[8]  = '{1'b0, 8'h0B, 32'h1234_5678};
      vecs[9]  = '{1'b0, 8'h04, 32'd0};
      vecs[10] = '{1'b1, 8'h04, 32'd1};
      vecs[11] = '{1'b0, 8'h00, status_base};
      vecs[12] = '{1'b0, 8'h0C, 32'd0};
      vecs[13] = '{1'b1, 8'h10, 32'hFFFF_FFFF};
      vecs[14] = '{1'b0, 8'h10, 32'd1};
      vecs[15] = '{1'b1, 8'h40, 32'h1111_1111};
      vecs[16] = '{1'b0, 8'h08, 32'h1234_5678};

      rst_i = 1'b1;
      axil_araddr_i = 8'd0; axil_arvalid_i = 1'b0; axil_rready_i = 1'b1;
      axil_awaddr_i = 8'd0; axil_awvalid_i = 1'b0; axil_wdata_i = 32'd0;
      axil_wvalid_i = 1'b0; axil_bready_i = 1'b1;
      dpi_valid_i = 1'b0; dpi_args_i = '0; emu_clk_en_i = 1'b0;

      repeat (2) @(negedge clk);
      chk1("rst_stall", stall_o, 1'b0);
      chk1("rst_irq", irq_o, 1'b0);
      chk1("rst_arready", axil_arready_o, 1'b0);
      chk1("rst_rvalid", axil_rvalid_o, 1'b0);
      chk1("rst_bvalid", axil_bvalid_o, 1'b0);
      chk1("rst_ret_valid", dpi_ret_valid_o, 1'b0);
      chk("rst_ret", dpi_ret_o, 32'd0);
      chk("rst_rdata", axil_rdata_o, 32'd0);
      rst_i = 1'b0;
      repeat (2) @(negedge clk);
      chk1("arready_up", axil_arready_o, 1'b1);
      chk1("awready_up", axil_awready_o, 1'b1);

      // register-access vector table (idle state)
      for (int i = 0; i < 17; i++) begin
         if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data);
         else            rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
      end

      // first call, args 1..4, irq enabled by the table
      dpi_args_i  = {32'd4, 32'd3, 32'd2, 32'd1};
      dpi_valid_i = 1'b1;
      #1;
      chk1("stall_same_cycle", stall_o, 1'b1);
      chk1("irq_before_capture", irq_o, 1'b0);
      @(negedge clk);
      chk1("stall_pending", stall_o, 1'b1);
      chk1("irq_pending", irq_o, 1'b1);
      dpi_args_i = {NA{32'hFFFF_FFFF}};
      for (int i = 0; i < NA; i++)
         rd_chk($sformatf("arg%0d", i), 8'(32 + 4 * i), 32'(i + 1));
      rd_chk("status_pending", 8'h00, status_base | 32'd1);
      axi_write(8'h08, 32'hCAFE_0001);
      axi_write(8'h04, 32'd1);
      m_count = m_count + 32'd1;
      chk("ret_value", dpi_ret_o, 32'hCAFE_0001);
      chk1("ret_valid", dpi_ret_valid_o, 1'b1);
      chk1("stall_retire", stall_o, 1'b0);
      chk1("irq_retire", irq_o, 1'b0);
      repeat (5) @(negedge clk);
      chk1("retire_held", dpi_ret_valid_o, 1'b1);
      rd_chk("status_retire", 8'h00, status_base | 32'd2);
      dpi_valid_i  = 1'b0;
      emu_clk_en_i = 1'b1;
      @(negedge clk);
      emu_clk_en_i = 1'b0;
      chk1("retired", dpi_ret_valid_o, 1'b0);
      chk1("stall_after_retire", stall_o, 1'b0);
      rd_chk("count_one", 8'h0C, m_count);
      rd_chk("status_idle", 8'h00, status_base);

      // back-to-back calls with dpi_valid_i held high
      dpi_args_i  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      dpi_valid_i = 1'b1;
      @(negedge clk);
      axi_write(8'h08, 32'h0000_0B01);
      axi_write(8'h04, 32'd1);
      m_count = m_count + 32'd1;
      chk("b2b_ret1", dpi_ret_o, 32'h0000_0B01);
      dpi_args_i   = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
      emu_clk_en_i = 1'b1;
      @(negedge clk);
      emu_clk_en_i = 1'b0;
      chk1("b2b_stall_comb", stall_o, 1'b1);
      chk1("b2b_ret_valid_low", dpi_ret_valid_o, 1'b0);
      @(negedge clk);
      rd_chk("b2b_arg0", 8'h20, 32'hB0);
      rd_chk("b2b_status", 8'h00, status_base | 32'd1);
      axi_write(8'h08, 32'h0000_0B02);
      axi_write(8'h04, 32'd1);
      m_count = m_count + 32'd1;
      chk("b2b_ret2", dpi_ret_o, 32'h0000_0B02);
      dpi_valid_i  = 1'b0;
      emu_clk_en_i = 1'b1;
      @(negedge clk);
      emu_clk_en_i = 1'b0;
      rd_chk("b2b_count", 8'h0C, m_count);

      // rvalid holds while rready is low
      @(negedge clk);
      axil_rready_i  = 1'b0;
      axil_araddr_i  = 8'h08;
      axil_arvalid_i = 1'b1;
      @(posedge clk);
      #1;
      axil_arvalid_i = 1'b0;
      repeat (4) @(negedge clk);
      chk1("rvalid_hold", axil_rvalid_o, 1'b1);
      chk("rdata_hold", axil_rdata_o, 32'h0000_0B02);
      axil_rready_i = 1'b1;
      @(negedge clk);
      chk1("rvalid_drop", axil_rvalid_o, 1'b0);

      // randomized calls against the call-level model
      for (int it = 0; it < 25; it++) begin
         ie = 1'($urandom_range(0, 1));
         axi_write(8'h10, {31'd0, ie});
         for (int j = 0; j < NA; j++) begin
            m_args[j] = $urandom;
            dpi_args_i[32*j +: 32] = m_args[j];
         end
         dpi_valid_i = 1'b1;
         @(negedge clk);
         chk1("rnd_stall", stall_o, 1'b1);
         chk1("rnd_irq", irq_o, ie);
         for (int j = 0; j < NA; j++) dpi_args_i[32*j +: 32] = $urandom;
         ai = $urandom_range(0, NA - 1);
         rd_chk("rnd_arg", 8'(32 + 4 * ai), m_args[ai]);
         res = $urandom;
         axi_write(8'h08, res);
         if ($urandom_range(0, 1) == 1) begin
            axi_write(8'h04, 32'hFFFF_FFFE);
            chk1("rnd_no_done", dpi_ret_valid_o, 1'b0);
         end
         axi_write(8'h04, $urandom | 32'd1);
         m_count = m_count + 32'd1;
         chk("rnd_ret", dpi_ret_o, res);
         chk1("rnd_ret_valid", dpi_ret_valid_o, 1'b1);
         chk1("rnd_stall_retire", stall_o, 1'b0);
         k = $urandom_range(0, 3);
         repeat (k) @(negedge clk);
         chk1("rnd_retire_held", dpi_ret_valid_o, 1'b1);
         dpi_valid_i  = 1'b0;
         emu_clk_en_i = 1'b1;
         @(negedge clk);
         emu_clk_en_i = 1'b0;
         chk1("rnd_retired", dpi_ret_valid_o, 1'b0);
         rd_chk("rnd_count", 8'h0C, m_count);
      end

      // reset pulsed during a pending call
      for (int j = 0; j < NA; j++) dpi_args_i[32*j +: 32] = 32'hA5A5_0000 | 32'(j + 1);
      dpi_valid_i = 1'b1;
      @(negedge clk);
      chk1("pre_rst_pending", stall_o, 1'b1);
      rst_i = 1'b1;
      @(negedge clk);
      chk1("rst_stall_tracks_hi", stall_o, 1'b1);
      chk1("rst_abort_ret_valid", dpi_ret_valid_o, 1'b0);
      dpi_valid_i = 1'b0;
      #1;
      chk1("rst_stall_tracks_lo", stall_o, 1'b0);
      @(negedge clk);
      rst_i = 1'b0;
      repeat (2) @(negedge clk);
      rd_chk("rst_arg0", 8'h20, 32'd0);
      rd_chk("rst_unmapped", 8'h40, 32'hDEAD_BEEF);
      rd_chk("rst_status", 8'h00, status_base);
      rd_chk("rst_count", 8'h0C, 32'd0);
      rd_chk("rst_result", 8'h08, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
